// File: rtl/rv32i_defs.sv
// RV32I architectural widths shared by every pipeline stage.
package rv32i_defs;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
endpackage

// File: rtl/rv_fetch_pkg.sv
// Fetch-stage types: one prefetch queue entry pairs an instruction with its address.
package rv_fetch_pkg;
  import rv32i_defs::*;

  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/rv_fetch_if.sv
// Fetch unit bus bundle: I_MEM request/response, redirect input and IF->ID handshake.
interface rv_fetch_if #(
  parameter int ADDR_WIDTH = rv32i_defs::ADDR_WIDTH,
  parameter int INST_WIDTH = rv32i_defs::INST_WIDTH
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [INST_WIDTH-1:0] imem_rsp_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [INST_WIDTH-1:0] if_inst;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [ADDR_WIDTH-1:0] if_next_pc;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_next_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_inst, if_pc, if_next_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: head read straight from storage flops, one-cycle push-to-visible.
// No internal backpressure; a push into a full FIFO without a same-cycle pop is dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] out_dat,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push_vld && ((count_q != FULL) || do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
endmodule

// File: rtl/rv_fetch_unit.sv
// RV32I fetch front end: credit-limited in-order I_MEM requests into a prefetch queue feeding ID.
// Response to if_valid is one cycle; issue stalls when queue slots plus in-flight requests run out.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH      = rv32i_defs::ADDR_WIDTH,
  parameter int INST_WIDTH      = rv32i_defs::INST_WIDTH,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  rv_fetch_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]           DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]         MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(PC_STEP);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  req_vld, req_fire, rsp_any, rsp_live, rsp_drop, pop;
  fetch_entry_t          push_entry, head_entry;

  // Credit only counts registered state so if_ready/imem_rsp never reach imem_req_valid.
  assign req_vld = !rst
                && (({1'b0, count} + {1'b0, outstanding_q}) < DEPTH_W)
                && (outstanding_q < MAX_OUT);

  always_comb begin
    redirect_aligned = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    req_fire         = req_vld && bus.imem_req_ready;
    rsp_any          = bus.imem_rsp_valid && (outstanding_q != '0);
    rsp_drop         = rsp_any && (discard_q != '0);
    rsp_live         = rsp_any && (discard_q == '0) && !bus.redirect_valid;
    pop              = bus.if_valid && bus.if_ready;
    push_entry.inst  = bus.imem_rsp_data;
    push_entry.pc    = rsp_pc_q;

    outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_any);
    discard_d     = discard_q - CW'(rsp_drop);
    fetch_pc_d    = req_fire ? fetch_pc_q + STEP : fetch_pc_q;
    rsp_pc_d      = rsp_live ? rsp_pc_q + STEP : rsp_pc_q;
    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      discard_d  = outstanding_d;
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_prefetch_q (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.redirect_valid),
    .push_vld (rsp_live),
    .push_dat (push_entry),
    .pop      (pop),
    .out_dat  (head_entry),
    .count    (count)
  );

  assign bus.imem_req_valid = req_vld;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = !rst && (count != '0);
  assign bus.if_inst        = head_entry.inst;
  assign bus.if_pc          = head_entry.pc;
  assign bus.if_next_pc     = head_entry.pc + STEP;
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Randomized bench: in-order memory model plus an expected PC stream that restarts on redirect.
module tb_rv_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv_fetch_if bus ();

  rv_fetch_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ready_pct, rsp_pct, ifr_pct, redir_pct;
  bit force_redir = 1'b0;
  logic [31:0] force_tgt = '0;
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  logic [31:0] exp_req = RST_PC;
  logic [31:0] exp_id  = RST_PC;
  int n_req = 0;
  int n_pop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // One cycle: drive inputs at the negedge, predict what the next posedge does.
  task automatic step(input bit r);
    bit redir, rsp_v, rdy, ifr;
    logic [31:0] tgt, a;
    int outst;
    @(negedge clk);
    rst = r;
    #1;
    outst = mq.size();
    redir = 1'b0;
    tgt   = '0;
    if (!r) begin
      redir = force_redir || ($urandom_range(0, 99) < redir_pct);
      if (force_redir) tgt = force_tgt;
      else if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else tgt = 32'h1000 + 32'($urandom_range(0, 4095));
      force_redir = 1'b0;
    end
    rsp_v = 1'b0;
    a     = '0;
    if (!r && outst != 0 && $urandom_range(0, 99) < rsp_pct) begin
      rsp_v = 1'b1;
      a     = mq.pop_front();
    end
    rdy = ($urandom_range(0, 99) < ready_pct);
    ifr = ($urandom_range(0, 99) < ifr_pct);

    if (r) begin
      chk("rst_req_vld", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_if_vld", 32'(bus.if_valid), 32'd0);
    end
    if (!r && bus.imem_req_valid) chk("credit", 32'(outst < MAXO), 32'd1);
    if (!r && bus.if_valid && ifr && !redir) begin
      chk("if_pc", bus.if_pc, exp_id);
      chk("if_inst", bus.if_inst, inst_of(exp_id));
      chk("if_next_pc", bus.if_next_pc, exp_id + 32'd4);
      popped.push_back(bus.if_pc);
      exp_id += 32'd4;
      n_pop++;
    end
    if (!r && bus.imem_req_valid && rdy) begin
      chk("req_addr", bus.imem_req_addr, exp_req);
      mq.push_back(bus.imem_req_addr);
      exp_req += 32'd4;
      n_req++;
    end
    if (redir) begin
      exp_req = {tgt[31:2], 2'b00};
      exp_id  = {tgt[31:2], 2'b00};
    end
    if (r) begin
      mq.delete();
      exp_req = RST_PC;
      exp_id  = RST_PC;
    end

    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp_v;
    bus.imem_rsp_data  = rsp_v ? inst_of(a) : 32'hDEAD_BEEF;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.if_ready       = ifr;
  endtask

  task automatic do_reset();
    repeat (2) step(1'b1);
    n_req = 0;
    n_pop = 0;
    popped.delete();
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;
    ready_pct = 100; rsp_pct = 100; ifr_pct = 100; redir_pct = 0;

    // Full-rate streaming from RESET_PC.
    do_reset();
    repeat (20) step(1'b0);
    chk("t1_req_rate", n_req, 32'd20);
    chk("t1_pops", n_pop, 32'd18);
    if (popped.size() > 0) chk("t1_first_pc", popped[0], RST_PC);

    // ID stall: exactly DEPTH requests, then drain and resume.
    ifr_pct = 0;
    do_reset();
    repeat (12) step(1'b0);
    chk("t2_req_cnt", n_req, 32'd4);
    chk("t2_req_stall", 32'(bus.imem_req_valid), 32'd0);
    ifr_pct = 100;
    n_req = 0; n_pop = 0; popped.delete();
    repeat (4) step(1'b0);
    chk("t2_drained", n_pop, 32'd4);
    if (popped.size() == 4) chk("t2_last_drain", popped[3], 32'h10C);
    repeat (8) step(1'b0);
    chk("t2_resume", n_req, 32'd11);

    // Redirect with two requests in flight.
    rsp_pct = 0;
    do_reset();
    repeat (3) step(1'b0);
    chk("t3_outst", mq.size(), 32'd2);
    rsp_pct = 100;
    force_redir = 1'b1; force_tgt = 32'h2000;
    step(1'b0);
    popped.delete();
    repeat (10) step(1'b0);
    chk("t3_pops", 32'(popped.size() >= 2), 32'd1);
    if (popped.size() >= 2) begin
      chk("t3_pc0", popped[0], 32'h2000);
      chk("t3_pc1", popped[1], 32'h2004);
    end

    // Redirect coinciding with a live response and a request handshake.
    do_reset();
    repeat (5) step(1'b0);
    force_redir = 1'b1; force_tgt = 32'h3000;
    step(1'b0);
    chk("t4_inflight", mq.size(), 32'd1);
    popped.delete();
    repeat (10) step(1'b0);
    if (popped.size() > 0) chk("t4_pc0", popped[0], 32'h3000);
    else chk("t4_pops", 32'd0, 32'd1);

    // Target alignment and address wrap.
    force_redir = 1'b1; force_tgt = 32'h2003;
    step(1'b0);
    @(posedge clk); #2;
    chk("t5_align", bus.imem_req_addr, 32'h2000);
    force_redir = 1'b1; force_tgt = 32'hFFFF_FFFC;
    step(1'b0);
    @(posedge clk); #2;
    chk("t5_wrap_pre", bus.imem_req_addr, 32'hFFFF_FFFC);
    n_req = 0;
    for (int i = 0; i < 10 && n_req == 0; i++) step(1'b0);
    @(posedge clk); #2;
    chk("t5_wrap", bus.imem_req_addr, 32'h0);

    // Reset mid-stream with a full queue.
    ifr_pct = 0;
    do_reset();
    repeat (8) step(1'b0);
    chk("t6_full", 32'(bus.if_valid), 32'd1);
    step(1'b1);
    step(1'b0);
    chk("t6_if_vld", 32'(bus.if_valid), 32'd0);
    chk("t6_addr", bus.imem_req_addr, RST_PC);

    // Randomized traffic under varying knobs.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      ready_pct = $urandom_range(30, 100);
      rsp_pct   = $urandom_range(20, 100);
      ifr_pct   = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 10);
      repeat (200) step(1'b0);
    end
    chk("rand_progress", 32'(n_pop > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
